mioc_flop_seq: RTL and testbench

- Synchronous command sequencer sitting directly upstream of the MIOC open-drain set/reset flop.
- Converts single-cycle SET/CLEAR/READ commands into glitch-free, width-controlled strobes on the flop's four inputs.
- Samples the flop's q/qbar feedback after settling and returns its state with an error code.
- Keeps set and reset strobes mutually exclusive.
- Holds the negedge-reset pair (in2/in3) strictly complementary at all times.

---
 rtl/mioc_flop_seq.sv | 167 ++++++++++++++++
 tb/tb_mioc_flop_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mioc_flop_seq.sv
// mioc_flop_seq: command sequencer in front of the MIOC open-drain SR flop.
// Turns single-cycle SET/CLR/READ commands into registered, width-controlled
// strobes, waits for the flop to settle, then reports synchronized q with a
// status code. All strobe outputs come straight from flops.
module mioc_flop_seq #(
  parameter int PW   = 2,  // strobe width in clocks, 1..255
  parameter int GAP  = 2,  // settle clocks after strobe release, 0..255
  parameter int SYNC = 2   // q/qbar synchronizer depth, 2..4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_q,
  output logic [1:0] rsp_err,
  output logic [7:0] err_cnt,
  output logic       fl_in1,
  output logic       fl_in2,
  output logic       fl_in3,
  output logic       fl_in4,
  input  logic       fl_q,
  input  logic       fl_qbar
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PULSE  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLRP = 2'b10;
  localparam logic [1:0] OP_CLRN = 2'b11;

  // Phase lengths as loaded into the 8-bit counter; settle is clamped so a
  // very large GAP cannot wrap the counter.
  localparam int         SETTLE_RAW = GAP + SYNC;
  localparam logic [7:0] SETTLE_LEN = (SETTLE_RAW > 255) ? 8'd255 : 8'(SETTLE_RAW);
  localparam logic [7:0] PW_LEN     = 8'(PW);

  logic [1:0]      state, state_n;
  logic [7:0]      cnt, cnt_n;
  logic [1:0]      op, op_n;
  logic            cap;
  logic [SYNC-1:0] q_sync, qb_sync;
  logic            qs, qbs;
  logic [1:0]      err_n;
  logic            pulse_n;

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

  assign qs  = q_sync[SYNC-1];
  assign qbs = qb_sync[SYNC-1];

  // Shift q/qbar through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sync  <= '0;
      qb_sync <= '0;
    end else begin
      q_sync  <= {q_sync[SYNC-2:0], fl_q};
      qb_sync <= {qb_sync[SYNC-2:0], fl_qbar};
    end
  end

  // Next-state / phase-counter logic; the counter holds remaining cycles.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op;
    cap     = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          op_n = cmd_op;
          if (cmd_op == OP_READ) begin
            state_n = S_SETTLE;
            cnt_n   = SETTLE_LEN;
          end else begin
            state_n = S_PULSE;
            cnt_n   = PW_LEN;
          end
        end
      end
      S_PULSE: begin
        if (cnt == 8'd1) begin
          state_n = S_SETTLE;
          cnt_n   = SETTLE_LEN;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      S_SETTLE: begin
        if (cnt == 8'd1) begin
          state_n = S_RESP;
          cnt_n   = 8'd0;
          cap     = 1'b1;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: begin
        cnt_n = 8'd0;
        if (rsp_ready) state_n = S_IDLE;
      end
    endcase
  end

  // Status of the synchronized feedback: invalid beats mismatch, READ never mismatches.
  always_comb begin
    err_n = 2'b00;
    if (qs == qbs)
      err_n = 2'b10;
    else if (op != OP_READ && qs != (op == OP_SET))
      err_n = 2'b01;
  end

  assign pulse_n = (state_n == S_PULSE);

  // FSM state, latched op and phase counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
      op    <= OP_READ;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op    <= op_n;
    end
  end

  // Response capture at the last settle edge, with saturating error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q   <= 1'b0;
      rsp_err <= 2'b00;
      err_cnt <= 8'd0;
    end else if (cap) begin
      rsp_q   <= qs;
      rsp_err <= err_n;
      if (err_n != 2'b00 && err_cnt != 8'hff)
        err_cnt <= err_cnt + 8'd1;
    end
  end

  // Strobes registered from next state so only one is ever active;
  // fl_in2/fl_in3 share one condition so they stay complementary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_in1 <= 1'b0;
      fl_in2 <= 1'b1;
      fl_in3 <= 1'b0;
      fl_in4 <= 1'b0;
    end else begin
      fl_in1 <= pulse_n && (op_n == OP_CLRP);
      fl_in4 <= pulse_n && (op_n == OP_SET);
      fl_in2 <= !(pulse_n && (op_n == OP_CLRN));
      fl_in3 <= pulse_n && (op_n == OP_CLRN);
    end
  end

endmodule

// File: tb/tb_mioc_flop_seq.sv
// Directed bench for mioc_flop_seq: vector table of commands against a
// behavioural SR-flop model, plus reset-mid-strobe and saturation sequences.
module tb_mioc_flop_seq;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLRP = 2'b10;
  localparam logic [1:0] OP_CLRN = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       rsp_ready = 1'b0;
  logic       fl_q, fl_qbar;

  logic       cmd_ready, rsp_valid, rsp_q, fl_in1, fl_in2, fl_in3, fl_in4;
  logic [1:0] rsp_err;
  logic [7:0] err_cnt;

  logic       cmd_ready_4, rsp_valid_4, rsp_q_4, fl_in1_4, fl_in2_4, fl_in3_4, fl_in4_4;
  logic [1:0] rsp_err_4;
  logic [7:0] err_cnt_4;

  int ntests = 0;
  int nfail  = 0;
  int exp_cnt = 0;

  // feedback mode: 0 follows model, 1 q=qbar=1, 2 stuck q=0, 3 stuck q=1
  int   mode = 0;
  logic mdl_q = 1'b0;

  always #5 clk = ~clk;

  mioc_flop_seq #(.PW(2), .GAP(2), .SYNC(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_err(rsp_err), .err_cnt(err_cnt),
    .fl_in1(fl_in1), .fl_in2(fl_in2), .fl_in3(fl_in3), .fl_in4(fl_in4),
    .fl_q(fl_q), .fl_qbar(fl_qbar));

  mioc_flop_seq #(.PW(4), .GAP(2), .SYNC(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_4),
    .cmd_op(cmd_op), .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q_4), .rsp_err(rsp_err_4), .err_cnt(err_cnt_4),
    .fl_in1(fl_in1_4), .fl_in2(fl_in2_4), .fl_in3(fl_in3_4), .fl_in4(fl_in4_4),
    .fl_q(fl_q), .fl_qbar(fl_qbar));

  // behavioural SR flop driven by the PW=2 instance
  always @(posedge clk) begin
    if (fl_in4) mdl_q <= 1'b1;
    else if (fl_in1 || fl_in3) mdl_q <= 1'b0;
  end

  assign fl_q    = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (mode == 3) ? 1'b1 : mdl_q;
  assign fl_qbar = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b1 : (mode == 3) ? 1'b0 : ~mdl_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // strobe exclusivity and in2/in3 complement, every cycle for both instances
  always @(negedge clk) begin
    chk("excl_pw2", {29'd0, fl_in1 & fl_in4, fl_in1 & ~fl_in2, fl_in3 ^ fl_in2}, 32'd1);
    chk("excl_pw4", {29'd0, fl_in1_4 & fl_in4_4, fl_in1_4 & ~fl_in2_4, fl_in3_4 ^ fl_in2_4}, 32'd1);
  end

  typedef struct {
    string      name;
    logic [1:0] op;
    int         mode;
    logic       exp_q;
    logic [1:0] exp_err;
    int         hold;
  } vec_t;

  vec_t vecs[10];

  task automatic run_cmd(input vec_t v);
    int lat, c1, c4, cn, first;
    int exp_pw, exp_lat;
    lat = -1; c1 = 0; c4 = 0; cn = 0; first = -1;
    exp_pw  = (v.op == OP_READ) ? 0 : 2;
    exp_lat = (v.op == OP_READ) ? 5 : 7;
    @(posedge clk); #1;
    mode = v.mode;
    cmd_valid = 1'b1; cmd_op = v.op;
    @(negedge clk);
    chk({v.name, "_ready"}, cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (fl_in1) c1++;
      if (fl_in4) c4++;
      if (!fl_in2) cn++;
      if ((fl_in1 || fl_in4 || !fl_in2) && first < 0) first = n;
      if (rsp_valid) begin lat = n; break; end
    end
    chk({v.name, "_lat"}, lat, exp_lat);
    chk({v.name, "_in4"}, c4, (v.op == OP_SET)  ? exp_pw : 0);
    chk({v.name, "_in1"}, c1, (v.op == OP_CLRP) ? exp_pw : 0);
    chk({v.name, "_in2"}, cn, (v.op == OP_CLRN) ? exp_pw : 0);
    if (v.op != OP_READ) chk({v.name, "_first"}, first, 1);
    chk({v.name, "_q"}, rsp_q, v.exp_q);
    chk({v.name, "_err"}, rsp_err, v.exp_err);
    if (v.exp_err != 2'b00 && exp_cnt < 255) exp_cnt++;
    chk({v.name, "_cnt"}, err_cnt, exp_cnt);
    chk({v.name, "_busy"}, cmd_ready, 0);
    for (int h = 0; h < v.hold; h++) begin
      if (h == 0) begin cmd_valid = 1'b1; cmd_op = OP_CLRP; end
      @(negedge clk);
      chk({v.name, "_hold_v"}, {rsp_valid, rsp_q, rsp_err, cmd_ready, fl_in1},
          {1'b1, v.exp_q, v.exp_err, 1'b0, 1'b0});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({v.name, "_done"}, {rsp_valid, cmd_ready}, 2'b01);
    chk({v.name, "_cnt2"}, err_cnt, exp_cnt);
  endtask

  initial begin
    vecs[0] = '{"set",        OP_SET,  0, 1'b1, 2'b00, 0};
    vecs[1] = '{"clrneg",     OP_CLRN, 0, 1'b0, 2'b00, 0};
    vecs[2] = '{"set2",       OP_SET,  0, 1'b1, 2'b00, 0};
    vecs[3] = '{"clrpos",     OP_CLRP, 0, 1'b0, 2'b00, 0};
    vecs[4] = '{"read0",      OP_READ, 0, 1'b0, 2'b00, 0};
    vecs[5] = '{"read_inv",   OP_READ, 1, 1'b1, 2'b10, 0};
    vecs[6] = '{"set_stuck",  OP_SET,  2, 1'b0, 2'b01, 10};
    vecs[7] = '{"clr_stuck",  OP_CLRP, 3, 1'b1, 2'b01, 0};
    vecs[8] = '{"read_one",   OP_READ, 3, 1'b1, 2'b00, 0};
    vecs[9] = '{"set3",       OP_SET,  0, 1'b1, 2'b00, 0};

    // reset state
    #12;
    chk("rst_outs", {cmd_ready, rsp_valid, rsp_q, rsp_err, fl_in1, fl_in2, fl_in3, fl_in4},
        {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0});
    chk("rst_cnt", err_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) run_cmd(vecs[i]);

    // reset pulled during cycle 2 of a PW=4 CLR_NEG
    @(posedge clk); #1;
    rst_n = 1'b0;
    mode = 0;
    #10;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmd_valid = 1'b1; cmd_op = OP_CLRN;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("p4_c1", {fl_in2_4, fl_in3_4}, 2'b01);
    @(negedge clk);
    chk("p4_c2", {fl_in2_4, fl_in3_4}, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("p4_rst_strobe", {fl_in2_4, fl_in3_4, fl_in1_4, fl_in4_4}, 4'b1000);
    chk("p4_rst_rsp", {rsp_valid_4, cmd_ready_4}, 2'b01);
    chk("p4_rst_cnt", err_cnt_4, 0);
    exp_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmd_valid = 1'b1; cmd_op = OP_SET;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    begin
      int lat4, c44;
      lat4 = -1; c44 = 0;
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (fl_in4_4) c44++;
        if (rsp_valid_4) begin lat4 = n; break; end
      end
      chk("p4_set_lat", lat4, 9);
      chk("p4_set_in4", c44, 4);
      chk("p4_set_rsp", {rsp_q_4, rsp_err_4}, 3'b100);
      chk("p4_set_cnt", err_cnt_4, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("p4_idle", {cmd_ready, cmd_ready_4}, 2'b11);

    // back-to-back invalid READs saturate err_cnt
    mode = 1;
    for (int i = 0; i < 300; i++) begin
      bit seen;
      seen = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = OP_READ;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int n = 1; n <= 20; n++) begin
        @(negedge clk);
        if (rsp_valid) begin seen = 1'b1; break; end
      end
      if (!seen) begin
        chk("sat_timeout", 0, 1);
        break;
      end
      if (exp_cnt < 255) exp_cnt++;
      if (i == 0 || i == 254 || i == 299) begin
        chk("sat_cnt", err_cnt, exp_cnt);
        chk("sat_err", rsp_err, 2'b10);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
    chk("sat_final", err_cnt, 255);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
